inbuf_fifo: RTL and testbench
=============================

INBUF_FIFO -- requirements
Module: inbuf_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of one input data line.
REQ-002 SHALL have parameter DEPTH, default 16, number of lines stored; power of 2, >=2.
REQ-003 SHALL have parameter AFULL_THR, default DEPTH-2, count at or above which afull asserts.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port eng_rstn  input  1  synchronous active-low engine flush.
REQ-007 SHALL have port wr_en  input  1  host write request.
REQ-008 SHALL have port wr_data  input  DATA_W  line to write.
REQ-009 SHALL have port full  output  1  no free entry.
REQ-010 SHALL have port afull  output  1  count >= AFULL_THR.
REQ-011 SHALL have port rd_rq  input  1  read request from input-buffer controller.
REQ-012 SHALL have port mem_en  input  1  read-side enable from controller; rd_rq is ignored when low.
REQ-013 SHALL have port empty  output  1  no stored line; drives the controller's empty input.
REQ-014 SHALL have port rd_data  output  DATA_W  line delivered to engine data registers.
REQ-015 SHALL have port rd_data_val  output  1  single-cycle pulse: rd_data updated this cycle.
REQ-016 SHALL have port count  output  $clog2(DEPTH+1)  stored-line occupancy.
REQ-017 SHALL have ports ovf, udf  output  1 each  sticky overflow/underflow flags (see REQ-034).

Function
REQ-018 SHALL accept a write (wr_acc) when wr_en=1 and full=0; wr_data is stored at the write pointer.
REQ-019 SHALL accept a read (rd_acc) when rd_rq=1, mem_en=1 and empty=0.
REQ-020 SHALL drive rd_data with the oldest line and pulse rd_data_val one cycle after rd_acc (latency 1).
REQ-021 SHALL hold rd_data unchanged between accepted reads; rd_data_val=0 in cycles without a preceding rd_acc.
REQ-022 SHALL keep write and read pointers of $clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-023 SHALL update count +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-024 SHALL derive full, afull and empty combinationally from registered count: full=(count==DEPTH), empty=(count==0).
REQ-025 When full, SHALL reject a write even if a read is accepted in the same cycle (no write-through).
REQ-026 When empty, SHALL reject a read even if a write is accepted in the same cycle (no bypass); data becomes readable the following cycle.
REQ-027 SHALL preserve FIFO order across pointer wrap-around.
REQ-028 Rejected writes and rejected reads SHALL leave pointers, count and storage unchanged.

Reset
REQ-029 On rstn=0, asynchronously: pointers=0, count=0, rd_data=0, rd_data_val=0, ovf=0, udf=0.
REQ-030 Reset outputs: full=0, afull=0 (AFULL_THR>0), empty=1, count=0.
REQ-031 Storage array SHALL NOT require reset.
REQ-032 On eng_rstn=0 at a clock edge: same values as REQ-029; takes priority over any simultaneous wr_acc/rd_acc, which are discarded.
REQ-033 A read accepted the cycle before eng_rstn=0 SHALL NOT produce rd_data_val.

Configuration
REQ-034 With macro INBUF_FIFO_ERR_FLAGS_EN defined: ovf sets when wr_en=1 and full=1; udf sets when rd_rq=1, mem_en=1, empty=1; both hold until rstn or eng_rstn.
REQ-035 Without INBUF_FIFO_ERR_FLAGS_EN: ovf and udf SHALL be constant 0, no flag registers.

Verification (DATA_W=64, DEPTH=4, AFULL_THR=2)
REQ-036 Write 0xA,0xB,0xC; then rd_rq with mem_en=1 three cycles -> rd_data 0xA,0xB,0xC each one cycle after request, rd_data_val high 3 cycles, empty=1 at end.
REQ-037 Write 5 lines back-to-back -> full=1 after 4th, 5th dropped, count=4, afull=1 from count=2; ovf=1 with macro, 0 without.
REQ-038 Full FIFO, simultaneous wr_en and rd_rq -> read accepted, write rejected, count=3.
REQ-039 Empty FIFO, simultaneous wr_en and rd_rq -> no rd_data_val, count=1; udf=1 with macro; next-cycle rd_rq returns written line.
REQ-040 Ten write/read pairs interleaved at count=2 -> pointers wrap, data order preserved, count stays 2.
REQ-041 Count=3, rd_rq accepted, eng_rstn=0 next cycle -> no rd_data_val, count=0, empty=1, rd_data=0; async rstn mid-stream gives same state immediately.

Source files
------------

// File: rtl/inbuf_fifo.sv
// inbuf_fifo: host-to-engine input line FIFO with 1-cycle registered read and engine flush.
// Define INBUF_FIFO_ERR_FLAGS_EN to get sticky ovf/udf error flags; otherwise they tie to 0.
module inbuf_fifo #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 16,
  parameter int AFULL_THR = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       eng_rstn,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  output logic                       afull,
  input  logic                       rd_rq,
  input  logic                       mem_en,
  output logic                       empty,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_data_val,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic                       udf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic val_q, wr_acc, rd_acc;
  assign full   = count == CW'(DEPTH);
  assign afull  = count >= CW'(AFULL_THR);
  assign empty  = count == '0;
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_rq & mem_en & ~empty;
  // a read accepted just before a flush must not show its pulse during the flush cycle
  assign rd_data_val = val_q & eng_rstn;
  always_ff @(posedge clk)
    if (wr_acc && eng_rstn) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      val_q   <= 1'b0;
    end else if (!eng_rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      val_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      val_q <= rd_acc;
      count <= count + CW'(wr_acc) - CW'(rd_acc);
    end
`ifdef INBUF_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (!eng_rstn) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en && full) ovf <= 1'b1;
      if (rd_rq && mem_en && empty) udf <= 1'b1;
    end
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif
endmodule

// File: tb/tb_inbuf_fifo.sv
// tb_inbuf_fifo: directed checks of inbuf_fifo at DEPTH=4, AFULL_THR=2.
module tb_inbuf_fifo;
`ifdef INBUF_FIFO_ERR_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0, eng_rstn = 1'b1;
  logic wr_en = 1'b0, rd_rq = 1'b0, mem_en = 1'b0;
  logic [63:0] wr_data = '0, rd_data;
  logic full, afull, empty, rd_data_val, ovf, udf;
  logic [2:0] count;
  int n_chk = 0, n_err = 0;
  inbuf_fifo #(.DATA_W(64), .DEPTH(4), .AFULL_THR(2)) dut (
    .clk(clk), .rstn(rstn), .eng_rstn(eng_rstn), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .afull(afull), .rd_rq(rd_rq), .mem_en(mem_en), .empty(empty),
    .rd_data(rd_data), .rd_data_val(rd_data_val), .count(count), .ovf(ovf), .udf(udf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [63:0] d);
    wr_en = 1'b1;
    wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [63:0] exp);
    rd_rq = 1'b1;
    mem_en = 1'b1;
    cyc();
    rd_rq = 1'b0;
    mem_en = 1'b0;
    chk({tag, "_val"}, rd_data_val, 1);
    chk({tag, "_data"}, rd_data, exp);
  endtask
  initial begin
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_val", rd_data_val, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    #9 rstn = 1'b1;
    cyc();
    wr(64'hA); wr(64'hB); wr(64'hC);
    chk("w3_count", count, 3);
    rd_rq = 1'b1;
    mem_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("seq_val", rd_data_val, 1);
      chk("seq_data", rd_data, 64'hA + 64'(i));
    end
    rd_rq = 1'b0;
    cyc();
    chk("seq_val_off", rd_data_val, 0);
    chk("seq_hold", rd_data, 64'hC);
    chk("seq_empty", empty, 1);
    wr(64'h11);
    rd_rq = 1'b1;
    mem_en = 1'b0;
    cyc();
    rd_rq = 1'b0;
    chk("memen_val", rd_data_val, 0);
    chk("memen_count", count, 1);
    rd("memen_rd", 64'h11);
    chk("memen_empty", empty, 1);
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1;
      wr_data = 64'(i);
      cyc();
      chk("fill_afull", afull, i >= 2);
      chk("fill_full", full, i >= 4);
    end
    wr_en = 1'b0;
    chk("fill_count", count, 4);
    chk("fill_ovf", ovf, FL);
    wr_en = 1'b1;
    wr_data = 64'h99;
    rd_rq = 1'b1;
    mem_en = 1'b1;
    cyc();
    wr_en = 1'b0;
    rd_rq = 1'b0;
    chk("fullrw_val", rd_data_val, 1);
    chk("fullrw_data", rd_data, 1);
    chk("fullrw_count", count, 3);
    rd("drain1", 2); rd("drain2", 3); rd("drain3", 4);
    chk("drain_empty", empty, 1);
    wr_en = 1'b1;
    wr_data = 64'h77;
    rd_rq = 1'b1;
    mem_en = 1'b1;
    cyc();
    wr_en = 1'b0;
    rd_rq = 1'b0;
    chk("emptyrw_val", rd_data_val, 0);
    chk("emptyrw_count", count, 1);
    chk("emptyrw_udf", udf, FL);
    rd("emptyrw_rd", 64'h77);
    wr(64'h100); wr(64'h101);
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1;
      wr_data = 64'h102 + 64'(i);
      rd_rq = 1'b1;
      mem_en = 1'b1;
      cyc();
      chk("wrap_data", rd_data, 64'h100 + 64'(i));
      chk("wrap_count", count, 2);
    end
    wr_en = 1'b0;
    rd_rq = 1'b0;
    rd("wrap_tail1", 64'h10A); rd("wrap_tail2", 64'h10B);
    wr(64'h201); wr(64'h202); wr(64'h203);
    rd_rq = 1'b1;
    mem_en = 1'b1;
    cyc();
    rd_rq = 1'b0;
    eng_rstn = 1'b0;
    #1;
    chk("flush_val_now", rd_data_val, 0);
    cyc();
    chk("flush_val", rd_data_val, 0);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_data", rd_data, 0);
    chk("flush_ovf", ovf, 0);
    chk("flush_udf", udf, 0);
    eng_rstn = 1'b1;
    wr(64'h301); wr(64'h302);
    rd("pre_arst", 64'h301);
    #2 rstn = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_data", rd_data, 0);
    chk("arst_val", rd_data_val, 0);
    #3 rstn = 1'b1;
    cyc();
    wr(64'h55);
    rd("post_arst", 64'h55);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
